// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that serialises single-word transactions from two
// requesters onto one shared memory port; every output is registered.
module mem_bus_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_rw,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic          m1_rw,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_datao,
  input  logic [DW-1:0] mem_data,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t     state;
  logic       gnt;
  logic       last_grant;
  logic [3:0] cnt;
  logic       pick_valid;
  logic       pick;

  // Contention goes to the port that did not win last time.
  always_comb begin
    pick_valid = m0_req | m1_req;
    if (m0_req && m1_req) pick = ~last_grant;
    else                  pick = m1_req;
  end

  // mem_address/mem_rw/mem_datao double as the latched transaction fields.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      last_grant  <= 1'b1;
      cnt         <= 4'd0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      mem_en      <= 1'b0;
      mem_rw      <= 1'b0;
      mem_address <= '0;
      mem_datao   <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt         <= pick;
            state       <= ACCESS;
            mem_en      <= 1'b1;
            busy        <= 1'b1;
            mem_rw      <= pick ? m1_rw    : m0_rw;
            mem_address <= pick ? m1_addr  : m0_addr;
            mem_datao   <= pick ? m1_wdata : m0_wdata;
          end
        end
        ACCESS: begin
          mem_en <= 1'b0;
          if (mem_rw) begin
            state  <= DONE;
            m0_ack <= ~gnt;
            m1_ack <= gnt;
          end else begin
            cnt   <= CNT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (gnt) m1_rdata <= mem_data;
            else     m0_rdata <= mem_data;
            m0_ack <= ~gnt;
            m1_ack <= gnt;
            state  <= DONE;
          end
        end
        DONE: begin
          m0_ack     <= 1'b0;
          m1_ack     <= 1'b0;
          last_grant <= gnt;
          busy       <= 1'b0;
          mem_rw     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter with MEM_LATENCY=3.
module tb_mem_bus_arbiter;

  localparam logic [31:0] JUNK = 32'hBAD0BAD0;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_req, m0_rw, m1_req, m1_rw;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack;
  logic        mem_en, mem_rw, busy;
  logic [31:0] mem_address, mem_datao, mem_data;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter #(.AW(32), .DW(32), .MEM_LATENCY(3)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_address(mem_address),
    .mem_datao(mem_datao), .mem_data(mem_data), .busy(busy)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 32'h4; m0_wdata = 32'h55;
    tick(); tick();
    total++; if ({m0_ack, m1_ack, mem_en, mem_rw, busy} !== 5'b0) begin bad++;
      $display("FAIL rst_ctrl got=%b exp=00000", {m0_ack, m1_ack, mem_en, mem_rw, busy}); end
    total++; if ({mem_address, mem_datao, m0_rdata, m1_rdata} !== 128'h0) begin bad++;
      $display("FAIL rst_data got=%h %h %h %h exp=0", mem_address, mem_datao, m0_rdata, m1_rdata); end
    // Both request; last_grant=1 after reset so port 0 must win.
    m1_req = 1'b1; m1_rw = 1'b1; m1_addr = 32'h8; m1_wdata = 32'h66;
    reset = 1'b0;
    tick();
    total++; if ({mem_en, mem_address} !== {1'b1, 32'h4}) begin bad++;
      $display("FAIL rst_first_grant got=%b %h exp=1 00000004", mem_en, mem_address); end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    total++; if ({m0_ack, m1_ack} !== 2'b10) begin bad++;
      $display("FAIL rst_first_ack got=%b exp=10", {m0_ack, m1_ack}); end
    tick();
  endtask

  task automatic test_write();
    m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
    tick();
    total++; if ({mem_en, mem_rw, mem_address, mem_datao, busy, m0_ack} !== {2'b11, 32'h10, 32'hDEADBEEF, 2'b10}) begin bad++;
      $display("FAIL wr_access got=%b%b %h %h busy=%b ack=%b exp=11 00000010 deadbeef busy=1 ack=0",
               mem_en, mem_rw, mem_address, mem_datao, busy, m0_ack); end
    tick();
    total++; if ({m0_ack, m1_ack, mem_en} !== 3'b100) begin bad++;
      $display("FAIL wr_ack got=%b exp=100", {m0_ack, m1_ack, mem_en}); end
    m0_req = 1'b0;
    tick();
    total++; if ({m0_ack, busy, mem_rw, m0_rdata} !== {3'b000, 32'h0}) begin bad++;
      $display("FAIL wr_idle got=%b %h exp=000 00000000", {m0_ack, busy, mem_rw}, m0_rdata); end
  endtask

  task automatic test_read();
    // Port 0 read first so m0_rdata holds a known nonzero value.
    m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 32'h18;
    tick(); m0_req = 1'b0;
    tick(); tick(); tick(); mem_data = 32'hCAFEF00D;
    tick(); mem_data = JUNK;
    total++; if ({m0_ack, m0_rdata} !== {1'b1, 32'hCAFEF00D}) begin bad++;
      $display("FAIL rd0_done got=%b %h exp=1 cafef00d", m0_ack, m0_rdata); end
    tick();
    // Port 1 read of 0x20; only the final WAIT cycle presents good data.
    m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 32'h20; m1_wdata = 32'h77;
    tick();
    total++; if ({mem_en, mem_rw, mem_address} !== {2'b10, 32'h20}) begin bad++;
      $display("FAIL rd1_access got=%b%b %h exp=10 00000020", mem_en, mem_rw, mem_address); end
    m1_req = 1'b0;
    tick();
    total++; if ({mem_en, mem_rw, busy, m1_ack, mem_address} !== {4'b0010, 32'h20}) begin bad++;
      $display("FAIL rd1_wait got=%b %h exp=0010 00000020", {mem_en, mem_rw, busy, m1_ack}, mem_address); end
    tick();
    total++; if (m1_ack !== 1'b0) begin bad++; $display("FAIL rd1_early_ack got=%b exp=0", m1_ack); end
    tick(); mem_data = 32'h12345678;
    total++; if (m1_ack !== 1'b0) begin bad++; $display("FAIL rd1_early_ack2 got=%b exp=0", m1_ack); end
    tick(); mem_data = JUNK;
    total++; if ({m1_ack, m0_ack, m1_rdata, m0_rdata} !== {2'b10, 32'h12345678, 32'hCAFEF00D}) begin bad++;
      $display("FAIL rd1_done got=%b %h %h exp=10 12345678 cafef00d", {m1_ack, m0_ack}, m1_rdata, m0_rdata); end
    tick();
    total++; if ({m1_ack, busy, m1_rdata} !== {2'b00, 32'h12345678}) begin bad++;
      $display("FAIL rd1_hold got=%b %h exp=00 12345678", {m1_ack, busy}, m1_rdata); end
  endtask

  task automatic test_contention();
    logic [31:0] exp_addr;
    logic        exp_port;
    m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 32'h100; m0_wdata = 32'hA0;
    m1_req = 1'b1; m1_rw = 1'b1; m1_addr = 32'h200; m1_wdata = 32'hB1;
    for (int i = 0; i < 4; i++) begin
      exp_port = i[0];
      exp_addr = exp_port ? 32'h200 : 32'h100;
      tick();
      total++; if ({mem_en, mem_address} !== {1'b1, exp_addr}) begin bad++;
        $display("FAIL cont_grant%0d got=%b %h exp=1 %h", i, mem_en, mem_address, exp_addr); end
      tick();
      total++; if ({m1_ack, m0_ack} !== {exp_port, ~exp_port}) begin bad++;
        $display("FAIL cont_ack%0d got=%b exp=%b", i, {m1_ack, m0_ack}, {exp_port, ~exp_port}); end
      tick();
      total++; if ({m1_ack, m0_ack, busy, mem_en} !== 4'b0000) begin bad++;
        $display("FAIL cont_idle%0d got=%b exp=0000", i, {m1_ack, m0_ack, busy, mem_en}); end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    total++; if ({m0_rdata, m1_rdata} !== {32'hCAFEF00D, 32'h12345678}) begin bad++;
      $display("FAIL cont_rdata_hold got=%h %h exp=cafef00d 12345678", m0_rdata, m1_rdata); end
  endtask

  task automatic test_abort();
    m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 32'h30;
    mem_data = 32'h99999999;
    tick(); m0_req = 1'b0;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_in_wait got=%b exp=1", busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if ({busy, m0_ack, mem_en, m0_rdata, m1_rdata} !== {3'b000, 64'h0}) begin bad++;
      $display("FAIL abort_state got=%b %h %h exp=000 0 0", {busy, m0_ack, mem_en}, m0_rdata, m1_rdata); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if ({m0_ack, busy, m0_rdata} !== {2'b00, 32'h0}) begin bad++;
        $display("FAIL abort_no_ack%0d got=%b %h exp=00 0", i, {m0_ack, busy}, m0_rdata); end
    end
    mem_data = JUNK;
  endtask

  task automatic test_early_drop();
    m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 32'h44; m0_wdata = 32'h1234;
    tick();
    m0_req = 1'b0; m0_addr = 32'hFFFF; m0_rw = 1'b0;
    total++; if ({mem_en, mem_rw, mem_address} !== {2'b11, 32'h44}) begin bad++;
      $display("FAIL drop_access got=%b %h exp=11 00000044", {mem_en, mem_rw}, mem_address); end
    tick();
    total++; if ({m0_ack, m1_ack} !== 2'b10) begin bad++;
      $display("FAIL drop_ack got=%b exp=10", {m0_ack, m1_ack}); end
    tick();
    total++; if ({m0_ack, busy} !== 2'b00) begin bad++;
      $display("FAIL drop_idle got=%b exp=00", {m0_ack, busy}); end
    tick();
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL drop_no_regrant got=%b exp=0", mem_en); end
  endtask

  initial begin
    reset = 1'b1;
    m0_req = 1'b0; m0_rw = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_rw = 1'b0; m1_addr = '0; m1_wdata = '0;
    mem_data = JUNK;
    #2;
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_abort();
    test_early_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-requester arbiter and sequencer for the single shared memory port of the CPU core. Port 0 is the CPU fetch/load-store path; port 1 is a secondary master (DMA or debug loader). The block serialises one single-word transaction at a time onto the memory bus. It uses round-robin arbitration and a per-port req/ack handshake.

Parameters:
AW, 32, address width.
DW, 32, data width.
MEM_LATENCY, 1, cycles from the ACCESS cycle until read data is valid on mem_data; legal range 1..15.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
m0_req  input  1  port 0 transaction request, level.
m0_rw  input  1  port 0 direction: 1 = write, 0 = read.
m0_addr  input  AW  port 0 word address.
m0_wdata  input  DW  port 0 write data.
m0_rdata  output  DW  port 0 read data, valid while m0_ack=1.
m0_ack  output  1  port 0 completion pulse, one cycle.
m1_req, m1_rw, m1_addr, m1_wdata, m1_rdata, m1_ack: same as port 0, for port 1.
mem_en  output  1  memory strobe.
mem_rw  output  1  memory direction: 1 = write.
mem_address  output  AW  memory address.
mem_datao  output  DW  memory write data.
mem_data  input  DW  memory read data.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (sync, active-high) clears every output to 0 and puts the FSM in IDLE with last_grant=1. An in-flight transaction is abandoned and no ack is issued. Reset takes priority over all other events.
- FSM states: IDLE, ACCESS, WAIT, DONE. All outputs are registered.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both are high, grant the port != last_grant.
  - On grant: latch the port id, rw, addr and wdata; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_en=1; mem_rw, mem_address and mem_datao are driven from the latched values.
  - Write: go to DONE.
  - Read: load a 4-bit counter with MEM_LATENCY-1 and go to WAIT.
- WAIT:
  - mem_en=0; mem_address and mem_rw hold the latched values.
  - Counter !=0: decrement.
  - Counter ==0: capture mem_data into the granted port's rdata register and go to DONE.
  - WAIT therefore lasts exactly MEM_LATENCY cycles.
- DONE (exactly 1 cycle):
  - Granted port's ack=1; the other port's ack=0.
  - Set last_grant to the granted port; go to IDLE.
- Latency, with req sampled high in IDLE at cycle t:
  - Write: ACCESS at t+1, ack at t+2.
  - Read: ACCESS at t+1, mem_data sampled at the end of cycle t+1+MEM_LATENCY, ack at t+2+MEM_LATENCY.
- Back-to-back minimum: one idle cycle between transactions (DONE to IDLE).
- Handshake rules:
  - A requester holds req until it sees ack, then deasserts req on the following edge.
  - If req is still high in the IDLE cycle after DONE, it is treated as a new transaction.
  - req, addr, rw and wdata are don't-care after the grant cycle because they are latched.
  - Dropping req mid-transaction does not cancel it; ack is still pulsed.
- rdata rules:
  - m*_rdata updates only on a read completing for that port.
  - Otherwise rdata holds its last value, including across writes and transactions of the other port.
- The non-granted port sees ack=0 throughout and keeps waiting; no starvation with both ports continuously requesting, because grants alternate.
- mem_en is never high outside ACCESS. mem_rw=0 in IDLE.

Test Plan:
- Reset: assert reset with m0_req=1 for 2 cycles -> all outputs 0, busy=0, no mem_en; first grant goes to port 0 after release.
- Single write: m0_req=1, m0_rw=1, addr=0x10, wdata=0xDEADBEEF at cycle t -> mem_en=1, mem_rw=1, mem_address=0x10, mem_datao=0xDEADBEEF at t+1; m0_ack=1 at t+2 only.
- Read with MEM_LATENCY=3: m1 read of addr=0x20, memory returns 0x12345678 -> ACCESS at t+1, WAIT t+2..t+4, m1_ack=1 and m1_rdata=0x12345678 at t+5; m0_rdata unchanged.
- Contention: both reqs held continuously for 4 transactions -> grants alternate 0,1,0,1; each ack is one cycle wide; one IDLE cycle between them.
- Abort: reset asserted during WAIT of an m0 read -> no m0_ack; FSM in IDLE next cycle; m0_rdata=0.
- Early req drop: m0 write request, m0_req deasserted in the ACCESS cycle -> transaction completes and m0_ack is still pulsed at t+2.
